// File: rtl/fcmp_pipe_if.sv
// Handshake and data bundle for the fcmp_pipe floating-point comparator.
// The master side offers operations and consumes results; the slave side
// is the comparator itself.
interface fcmp_pipe_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 4
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     op1;
  logic [W-1:0]     op2;
  logic [1:0]       mode;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic             result;
  logic             invalid;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, op1, op2, mode, in_tag, out_ready,
    input  in_ready, out_valid, result, invalid, out_tag
  );

  modport slave (
    input  in_valid, op1, op2, mode, in_tag, out_ready,
    output in_ready, out_valid, result, invalid, out_tag
  );
endinterface

// File: rtl/fcmp_pipe.sv
// Two-stage pipelined IEEE-style floating-point comparator.
// S1 latches operand classification and the raw magnitude compare;
// S2 turns that into the mode-specific result, invalid flag and tag.
// Valid/ready handshake on both sides, full throughput, no bubbles.
module fcmp_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 4
) (
  input  logic        clk,
  input  logic        rstn,
  fcmp_pipe_if.slave  bus
);
  localparam int W = 1 + EXP_W + MAN_W;

  // NaN: exponent all ones with a nonzero mantissa (infinity is ordered)
  function automatic logic is_nan(input logic [W-1:0] v);
    return (&v[W-2:MAN_W]) && (|v[MAN_W-1:0]);
  endfunction

  // stage 1 state
  logic             s1_valid_reg;
  logic             s1_nan_reg;
  logic             s1_zero_reg;
  logic             s1_sign1_reg;
  logic             s1_sign2_reg;
  logic             s1_mag_lt_reg;
  logic             s1_mag_eq_reg;
  logic [1:0]       s1_mode_reg;
  logic [TAG_W-1:0] s1_tag_reg;

  // stage 2 state (drives the output port)
  logic             s2_valid_reg;
  logic             s2_result_reg;
  logic             s2_invalid_reg;
  logic [TAG_W-1:0] s2_tag_reg;

  logic             in_fire;
  logic             s2_load;
  logic [W-2:0]     mag1;
  logic [W-2:0]     mag2;
  logic             ord_lt;
  logic             ord_eq;
  logic             result_next;
  logic             invalid_next;

  // S1 may take a new operation unless both stages are full and the output stalls
  assign bus.in_ready = !s1_valid_reg || !s2_valid_reg || bus.out_ready;
  assign in_fire      = bus.in_valid && bus.in_ready;
  assign s2_load      = s1_valid_reg && (!s2_valid_reg || bus.out_ready);

  assign mag1 = bus.op1[W-2:0];
  assign mag2 = bus.op2[W-2:0];

  assign bus.out_valid = s2_valid_reg;
  assign bus.result    = s2_result_reg;
  assign bus.invalid   = s2_invalid_reg;
  assign bus.out_tag   = s2_tag_reg;

  // Stage 1: classify operands and compare magnitudes on accept
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid_reg  <= 1'b0;
      s1_nan_reg    <= 1'b0;
      s1_zero_reg   <= 1'b0;
      s1_sign1_reg  <= 1'b0;
      s1_sign2_reg  <= 1'b0;
      s1_mag_lt_reg <= 1'b0;
      s1_mag_eq_reg <= 1'b0;
      s1_mode_reg   <= 2'b00;
      s1_tag_reg    <= '0;
    end else begin
      if (in_fire) begin
        s1_valid_reg  <= 1'b1;
        s1_nan_reg    <= is_nan(bus.op1) || is_nan(bus.op2);
        s1_zero_reg   <= (mag1 == '0) && (mag2 == '0);
        s1_sign1_reg  <= bus.op1[W-1];
        s1_sign2_reg  <= bus.op2[W-1];
        s1_mag_lt_reg <= mag1 < mag2;
        s1_mag_eq_reg <= mag1 == mag2;
        s1_mode_reg   <= bus.mode;
        s1_tag_reg    <= bus.in_tag;
      end else if (s2_load) begin
        s1_valid_reg  <= 1'b0;
      end
    end
  end

  // Resolve signed ordering and apply the requested predicate
  always_comb begin
    ord_lt       = 1'b0;
    ord_eq       = 1'b0;
    result_next  = 1'b0;
    invalid_next = 1'b0;
    if (s1_zero_reg) begin
      ord_eq = 1'b1;                       // +0 == -0
    end else if (s1_sign1_reg != s1_sign2_reg) begin
      ord_lt = s1_sign1_reg;               // the negative operand is smaller
    end else if (!s1_sign1_reg) begin
      ord_lt = s1_mag_lt_reg;
      ord_eq = s1_mag_eq_reg;
    end else begin
      ord_lt = !s1_mag_lt_reg && !s1_mag_eq_reg;  // negatives order reversed
      ord_eq = s1_mag_eq_reg;
    end
    case (s1_mode_reg)
      2'b00:   result_next = ord_lt && !s1_nan_reg;
      2'b01:   result_next = (ord_lt || ord_eq) && !s1_nan_reg;
      2'b10:   result_next = ord_eq && !s1_nan_reg;
      default: result_next = s1_nan_reg;
    endcase
    invalid_next = s1_nan_reg && !s1_mode_reg[1];
  end

  // Stage 2: output register, held while the consumer stalls
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s2_valid_reg   <= 1'b0;
      s2_result_reg  <= 1'b0;
      s2_invalid_reg <= 1'b0;
      s2_tag_reg     <= '0;
    end else begin
      if (s2_load) begin
        s2_valid_reg   <= 1'b1;
        s2_result_reg  <= result_next;
        s2_invalid_reg <= invalid_next;
        s2_tag_reg     <= s1_tag_reg;
      end else if (bus.out_ready) begin
        s2_valid_reg   <= 1'b0;
      end
    end
  end
endmodule
